// File: rtl/risc_phase_sequencer.sv
// risc_phase_sequencer
//   Produces the 3-bit instruction phase (0..7) for the VeriRISC controller.
//   cpu_en gates the datapath register loads. The block adds run, halt and
//   single-step control. It inserts memory wait states, raises a sticky bus
//   timeout when an access stalls too long, and counts retired instructions.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   run_req, step_req : resume / single-instruction requests (used only in HALTED)
//   halt              : controller HLT indication (acts on phase 4)
//   rd, wr, mem_ready : memory access request of the current phase / completion
//   phase, cpu_en     : phase to controller, advance enable
//   running, halted   : FSM status
//   bus_timeout       : sticky, set on entering ERR
//   instr_count       : phase 7->0 transitions, wraps
module risc_phase_sequencer #(
    parameter int WAIT_MAX  = 15,
    parameter bit START_RUN = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt,
    input  logic             rd,
    input  logic             wr,
    input  logic             mem_ready,
    output logic [2:0]       phase,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic             bus_timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_WAIT   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam state_t RESET_STATE = START_RUN ? S_RUN : S_HALTED;

    state_t           state, state_n;
    logic [2:0]       phase_n;
    logic [CNT_W-1:0] count_n;
    logic [7:0]       wait_cnt, wait_cnt_n;
    logic             wait_from_step, wait_from_step_n;
    logic             timeout_n;
    logic             active;
    logic             stall;

    // Executing states; a pending access without ready stalls the phase.
    assign active = (state == S_RUN) || (state == S_STEP);
    assign stall  = (rd | wr) & ~mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RESET_STATE;
            phase          <= 3'd0;
            instr_count    <= '0;
            wait_cnt       <= 8'd0;
            wait_from_step <= 1'b0;
            bus_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            phase          <= phase_n;
            instr_count    <= count_n;
            wait_cnt       <= wait_cnt_n;
            wait_from_step <= wait_from_step_n;
            bus_timeout    <= timeout_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n          = state;
        phase_n          = phase;
        count_n          = instr_count;
        wait_cnt_n       = wait_cnt;
        wait_from_step_n = wait_from_step;
        timeout_n        = bus_timeout;
        case (state)
            S_HALTED: begin
                if (run_req)       state_n = S_RUN;
                else if (step_req) state_n = S_STEP;
            end
            S_RUN, S_STEP: begin
                if (stall) begin
                    state_n          = S_WAIT;
                    wait_cnt_n       = 8'd1;
                    wait_from_step_n = (state == S_STEP);
                end else begin
                    phase_n = phase + 3'd1;
                    if (phase == 3'd7) begin
                        count_n = instr_count + CNT_W'(1);
                        // A single step ends once the instruction retires.
                        if (state == S_STEP) state_n = S_HALTED;
                    end
                    // Halting still steps past phase 4 so a resume does not re-halt.
                    if (phase == 3'd4 && halt) state_n = S_HALTED;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    // Phase is re-evaluated in the origin state on the next cycle.
                    state_n    = wait_from_step ? S_STEP : S_RUN;
                    wait_cnt_n = 8'd0;
                end else if (wait_cnt == 8'(WAIT_MAX)) begin
                    state_n   = S_ERR;
                    timeout_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = RESET_STATE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_en  = active & ~stall;
        running = active || (state == S_WAIT);
        halted  = (state == S_HALTED);
    end

endmodule
